perf_monitor: RTL and testbench
===============================

PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter LANES, default 2: number of writeback retire lanes observed per cycle (1..4).
REQ-002 Parameter CNT_W, default 32: width of every counter (16..64).
REQ-003 Parameter WINDOW, default 1000: sample window length in unfrozen cycles (>=2).
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 reset_i  in  1  asynchronous, active-low reset; asserted when 0.
REQ-006 valid_wb_i  in  LANES  per-lane writeback valid.
REQ-007 stall_wb_i  in  1  writeback stall, shared by all lanes.
REQ-008 instr_wb_i  in  LANES x 32  per-lane instruction word at writeback.
REQ-009 clear_i  in  1  synchronous clear of all counters, overflow flags and window count.
REQ-010 freeze_i  in  1  holds all counters and the window count while high.
REQ-011 rd_sel_i  in  3  counter index for the read port (0..6).
REQ-012 rd_snap_i  in  1  read port source: 1 = snapshot bank, 0 = live counters.
REQ-013 rd_data_o  out  CNT_W  registered read data.
REQ-014 ovf_o  out  7  sticky per-counter saturation flags, bit i = counter index i.
REQ-015 snap_valid_o  out  1  one-cycle pulse when a snapshot is captured.

Function
REQ-016 Counter indices SHALL be 0 cycle, 1 retire, 2 alu, 3 load, 4 store, 5 branch, 6 other.
REQ-017 Lane k SHALL retire in a cycle when valid_wb_i[k]=1, stall_wb_i=0 and instr_wb_i[k] != 32'h0000_0013 (NOP).
REQ-018 Class decode on instr[6:0]: R-type, I-type ALU, AUIPC, LUI -> alu; B-type, JAL, JALR -> branch; I-type load -> load; S-type -> store; any other opcode -> other.
REQ-019 Each cycle with freeze_i=0 and clear_i=0, the cycle counter SHALL add 1, the retire counter SHALL add the number of retiring lanes (0..LANES), and each class counter SHALL add the number of retiring lanes of that class.
REQ-020 Increment sums SHALL be computed at $clog2(LANES+1) bits and zero-extended to CNT_W.
REQ-021 A counter whose sum exceeds 2^CNT_W-1 SHALL saturate at 2^CNT_W-1 and set its ovf_o bit; it SHALL NOT wrap.
REQ-022 The window counter SHALL advance on each unfrozen cycle, counting 0..WINDOW-1 then wrapping to 0.
REQ-023 On the cycle the window counter equals WINDOW-1 and is advancing, all seven counters' post-update values SHALL be copied into the snapshot bank and snap_valid_o SHALL pulse high on the following cycle.
REQ-024 clear_i SHALL take priority over freeze_i and over counting; counters, ovf_o and window count go to 0 on the next edge; the snapshot bank SHALL be retained.
REQ-025 clear_i coinciding with a window end SHALL capture the pre-clear post-update values into the snapshot, then clear.
REQ-026 freeze_i=1 SHALL suppress counting, window advance and snapshot capture; retirements during freeze are not counted.
REQ-027 rd_data_o SHALL present the selected counter one cycle after rd_sel_i/rd_snap_i are sampled; rd_sel_i=7 SHALL read 0.
REQ-028 Read of a live counter SHALL return its value before that cycle's update.

Reset
REQ-029 While reset_i=0, all counters, snapshot bank, window count, ovf_o, rd_data_o and snap_valid_o SHALL be 0, independent of clk_i.
REQ-030 Counting SHALL start on the first rising edge with reset_i=1; reset asserted mid-window SHALL discard the partial window without a snapshot.

Structure
REQ-031 Package perf_mon_pkg SHALL hold the counter-index enum, NUM_CNT=7, the instruction-class enum and the NOP constant; opcode values come from the existing instruction macros.
REQ-032 Sub-module perf_classify SHALL decode one lane (valid, stall, instr -> one-hot class, retire bit), instantiated LANES times.

Verification
REQ-033 LANES=2: 10 cycles each with both lanes retiring ADD -> live cycle=10, retire=20, alu=20, others 0.
REQ-034 Lane 0 NOP, lane 1 LW with stall_wb_i high for 3 of 5 cycles -> retire=2, load=2.
REQ-035 WINDOW=4, one SW per cycle -> snap_valid_o pulses after cycles 4 and 8; snapshot store=4 then 8.
REQ-036 CNT_W=16, preload via 65534 cycles then 2 dual-lane retirements -> cycle saturates at 65535, ovf_o[0]=1; clear_i -> all 0, ovf_o=0.
REQ-037 freeze_i high for 5 cycles with JAL retiring -> branch and cycle unchanged; clear_i with freeze_i -> counters 0.
REQ-038 Drop reset_i to 0 mid-window between edges -> all outputs 0 immediately; no snap_valid_o pulse.

Source files
------------

// File: rtl/perf_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_mon_pkg
// Description : Shared types and constants for the writeback performance monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_mon_pkg;

    localparam int NUM_CNT = 7;
    localparam int NUM_CLS = 5;

    typedef enum logic [2:0] {
        CNT_CYCLE  = 3'd0,
        CNT_RETIRE = 3'd1,
        CNT_ALU    = 3'd2,
        CNT_LOAD   = 3'd3,
        CNT_STORE  = 3'd4,
        CNT_BRANCH = 3'd5,
        CNT_OTHER  = 3'd6
    } cnt_idx_e;

    // Class encoding is ordered so that counter index = CNT_ALU + class.
    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_OTHER  = 3'd4
    } instr_cls_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    function automatic instr_cls_e decode_class(input logic [6:0] opcode);
        instr_cls_e cls;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_AUIPC, OPC_LUI: cls = CLS_ALU;
            OPC_BRANCH, OPC_JAL, OPC_JALR:          cls = CLS_BRANCH;
            OPC_LOAD:                               cls = CLS_LOAD;
            OPC_STORE:                              cls = CLS_STORE;
            default:                                cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/perf_classify.sv
`default_nettype none
// ============================================================================
// Module      : perf_classify
// Description : Per-lane retire qualification and one-hot instruction class.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_classify
    import perf_mon_pkg::*;
(
    input  logic               valid,
    input  logic               stall,
    input  logic [31:0]        instr,
    output logic               retire,
    output logic [NUM_CLS-1:0] cls_onehot
);

    instr_cls_e w_cls;

    // The class vector is gated by retire so the top can sum it directly.
    always_comb begin
        w_cls      = decode_class(instr[6:0]);
        retire     = valid && !stall && (instr != NOP_INSTR);
        cls_onehot = retire ? (NUM_CLS'(1) << w_cls) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : perf_monitor
// Description : Saturating retire/class counters with windowed snapshot bank.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int CNT_W  = 32,
    parameter int WINDOW = 1000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [LANES-1:0]      valid_wb_i,
    input  logic                  stall_wb_i,
    input  logic [LANES-1:0][31:0] instr_wb_i,
    input  logic                  clear_i,
    input  logic                  freeze_i,
    input  logic [2:0]            rd_sel_i,
    input  logic                  rd_snap_i,
    output logic [CNT_W-1:0]      rd_data_o,
    output logic [NUM_CNT-1:0]    ovf_o,
    output logic                  snap_valid_o
);

    localparam int                 SUM_W    = $clog2(LANES + 1);
    localparam int                 WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    logic [LANES-1:0]                w_retire;
    logic [LANES-1:0][NUM_CLS-1:0]   w_cls;
    logic [NUM_CNT-1:0][SUM_W-1:0]   w_inc;
    logic [NUM_CNT-1:0][CNT_W:0]     w_sum;
    logic [NUM_CNT-1:0][CNT_W-1:0]   w_cnt_upd;
    logic [NUM_CNT-1:0]              w_sat;
    logic                            w_capture;
    logic [CNT_W-1:0]                w_rd;

    logic [NUM_CNT-1:0][CNT_W-1:0]   r_cnt;
    logic [NUM_CNT-1:0][CNT_W-1:0]   r_snap;
    logic [NUM_CNT-1:0]              r_ovf;
    logic [WIN_W-1:0]                r_win;
    logic                            r_snap_valid;
    logic [CNT_W-1:0]                r_rd_data;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            perf_classify u_classify (
                .valid      (valid_wb_i[k]),
                .stall      (stall_wb_i),
                .instr      (instr_wb_i[k]),
                .retire     (w_retire[k]),
                .cls_onehot (w_cls[k])
            );
        end
    endgenerate

    always_comb begin
        w_inc            = '0;
        w_inc[CNT_CYCLE] = SUM_W'(1);
        for (int k = 0; k < LANES; k++) begin
            w_inc[CNT_RETIRE] = w_inc[CNT_RETIRE] + SUM_W'(w_retire[k]);
            for (int c = 0; c < NUM_CLS; c++) begin
                w_inc[CNT_ALU + c] = w_inc[CNT_ALU + c] + SUM_W'(w_cls[k][c]);
            end
        end
    end

    // One extra carry bit detects overflow; saturate instead of wrapping.
    always_comb begin
        w_sum     = '0;
        w_cnt_upd = '0;
        w_sat     = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            w_sum[i]     = {1'b0, r_cnt[i]} + (CNT_W + 1)'(w_inc[i]);
            w_sat[i]     = w_sum[i][CNT_W];
            w_cnt_upd[i] = w_sat[i] ? CNT_MAX : w_sum[i][CNT_W-1:0];
        end
    end

    // Capture depends only on freeze so a clear at window end still snapshots.
    assign w_capture = !freeze_i && (r_win == WIN_LAST);

    always_comb begin
        w_rd = '0;
        if (rd_sel_i < 3'(NUM_CNT)) begin
            w_rd = rd_snap_i ? r_snap[rd_sel_i] : r_cnt[rd_sel_i];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt        <= '0;
            r_snap       <= '0;
            r_ovf        <= '0;
            r_win        <= '0;
            r_snap_valid <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_snap_valid <= w_capture;
            r_rd_data    <= w_rd;
            if (w_capture) begin
                r_snap <= w_cnt_upd;
            end
            if (clear_i) begin
                r_cnt <= '0;
                r_ovf <= '0;
                r_win <= '0;
            end else if (!freeze_i) begin
                r_cnt <= w_cnt_upd;
                r_ovf <= r_ovf | w_sat;
                r_win <= (r_win == WIN_LAST) ? '0 : r_win + 1'b1;
            end
        end
    end

    assign rd_data_o    = r_rd_data;
    assign ovf_o        = r_ovf;
    assign snap_valid_o = r_snap_valid;

endmodule
`default_nettype wire

// File: tb/tb_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_monitor
// Description : Directed and random checks of perf_monitor against a counting model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_monitor;

    localparam int    LANES  = 2;
    localparam int    CNT_W  = 16;
    localparam int    WINDOW = 4;
    localparam longint MAXV  = (64'd1 << CNT_W) - 1;

    localparam logic [31:0] I_NOP   = 32'h0000_0013;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_ADDI  = 32'h0010_0093;
    localparam logic [31:0] I_AUIPC = 32'h0000_0117;
    localparam logic [31:0] I_LUI   = 32'h0000_10B7;
    localparam logic [31:0] I_BEQ   = 32'h0020_8463;
    localparam logic [31:0] I_JAL   = 32'h0080_00EF;
    localparam logic [31:0] I_JALR  = 32'h0000_80E7;
    localparam logic [31:0] I_LW    = 32'h0000_A103;
    localparam logic [31:0] I_SW    = 32'h0020_A023;
    localparam logic [31:0] I_FENCE = 32'h0000_000F;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [LANES-1:0]       valid = '0;
    logic                   stall = 1'b0;
    logic [LANES-1:0][31:0] instr = '0;
    logic                   clear = 1'b0;
    logic                   freeze = 1'b0;
    logic [2:0]             rd_sel = '0;
    logic                   rd_snap = 1'b0;
    logic [CNT_W-1:0]       rd_data;
    logic [6:0]             ovf;
    logic                   snap_valid;

    int n_cmp = 0;
    int n_err = 0;

    longint     m_cnt [7];
    longint     m_snap[7];
    int         m_win;
    logic [6:0] m_ovf;

    perf_monitor #(.LANES(LANES), .CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
        .clk_i        (clk),
        .reset_i      (reset_n),
        .valid_wb_i   (valid),
        .stall_wb_i   (stall),
        .instr_wb_i   (instr),
        .clear_i      (clear),
        .freeze_i     (freeze),
        .rd_sel_i     (rd_sel),
        .rd_snap_i    (rd_snap),
        .rd_data_o    (rd_data),
        .ovf_o        (ovf),
        .snap_valid_o (snap_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counter index of an instruction per the opcode class table.
    function automatic int class_idx(input logic [31:0] ins);
        case (ins[6:0])
            7'h33, 7'h13, 7'h17, 7'h37: return 2;
            7'h03:                      return 3;
            7'h23:                      return 4;
            7'h63, 7'h6F, 7'h67:        return 5;
            default:                    return 6;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
        end
        m_win = 0;
        m_ovf = '0;
    endtask

    task automatic step(input logic [1:0] v, input logic st, input logic [31:0] i0,
                        input logic [31:0] i1, input logic clr, input logic frz,
                        input logic [2:0] sel, input logic snp);
        longint     nxt[7];
        longint     exp_rd;
        logic       cap;
        logic [6:0] sat;
        logic [31:0] ins[2];
        valid = v; stall = st; instr[0] = i0; instr[1] = i1;
        clear = clr; freeze = frz; rd_sel = sel; rd_snap = snp;
        ins[0] = i0; ins[1] = i1;
        exp_rd = (sel == 3'd7) ? 0 : (snp ? m_snap[sel] : m_cnt[sel]);
        nxt = m_cnt;
        nxt[0] += 1;
        for (int k = 0; k < 2; k++) begin
            if (v[k] && !st && ins[k] != I_NOP) begin
                nxt[1] += 1;
                nxt[class_idx(ins[k])] += 1;
            end
        end
        sat = '0;
        for (int i = 0; i < 7; i++) begin
            if (nxt[i] > MAXV) begin
                nxt[i] = MAXV;
                sat[i] = 1'b1;
            end
        end
        cap = !frz && (m_win == WINDOW - 1);
        if (cap) m_snap = nxt;
        if (clr) begin
            for (int i = 0; i < 7; i++) m_cnt[i] = 0;
            m_ovf = '0;
            m_win = 0;
        end else if (!frz) begin
            m_cnt = nxt;
            m_ovf = m_ovf | sat;
            m_win = (m_win + 1) % WINDOW;
        end
        @(posedge clk);
        #1;
        chk("rd_data", 64'(rd_data), 64'(exp_rd));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("snap_valid", 64'(snap_valid), 64'(cap));
    endtask

    task automatic readout(input logic [2:0] sel, input logic snp);
        step(2'b00, 1'b0, I_NOP, I_NOP, 1'b0, 1'b1, sel, snp);
    endtask

    task automatic do_clear();
        step(2'b00, 1'b0, I_NOP, I_NOP, 1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] pool[11];
        pool = '{I_NOP, I_ADD, I_ADDI, I_AUIPC, I_LUI, I_BEQ, I_JAL, I_JALR, I_LW, I_SW, I_FENCE};
        if ($urandom_range(0, 7) == 0) return $urandom;
        return pool[$urandom_range(0, 10)];
    endfunction

    initial begin
        model_reset();
        #12;
        chk("reset_rd", 64'(rd_data), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_snapv", 64'(snap_valid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Both lanes retiring ADD for 10 cycles
        do_clear();
        repeat (10) step(2'b11, 1'b0, I_ADD, I_ADD, 1'b0, 1'b0, 3'd1, 1'b0);
        readout(3'd0, 1'b0); chk("dual_add_cycle", 64'(rd_data), 64'd10);
        readout(3'd1, 1'b0); chk("dual_add_retire", 64'(rd_data), 64'd20);
        readout(3'd2, 1'b0); chk("dual_add_alu", 64'(rd_data), 64'd20);
        readout(3'd3, 1'b0); chk("dual_add_load", 64'(rd_data), 64'd0);
        readout(3'd7, 1'b0); chk("sel7_zero", 64'(rd_data), 64'd0);

        // NOP lane 0, LW lane 1, stalled on 3 of 5 cycles
        do_clear();
        step(2'b11, 1'b1, I_NOP, I_LW, 1'b0, 1'b0, 3'd0, 1'b0);
        step(2'b11, 1'b0, I_NOP, I_LW, 1'b0, 1'b0, 3'd0, 1'b0);
        step(2'b11, 1'b1, I_NOP, I_LW, 1'b0, 1'b0, 3'd0, 1'b0);
        step(2'b11, 1'b0, I_NOP, I_LW, 1'b0, 1'b0, 3'd0, 1'b0);
        step(2'b11, 1'b1, I_NOP, I_LW, 1'b0, 1'b0, 3'd0, 1'b0);
        readout(3'd1, 1'b0); chk("stall_retire", 64'(rd_data), 64'd2);
        readout(3'd3, 1'b0); chk("stall_load", 64'(rd_data), 64'd2);

        // Window of 4 with one store per cycle
        do_clear();
        for (int c = 1; c <= 8; c++) begin
            step(2'b01, 1'b0, I_SW, I_NOP, 1'b0, 1'b0, 3'd4, 1'b1);
            if (c == 4 || c == 8) chk("snapv_window", 64'(snap_valid), 64'd1);
            if (c == 5) chk("snap_store4", 64'(rd_data), 64'd4);
        end
        readout(3'd4, 1'b1); chk("snap_store8", 64'(rd_data), 64'd8);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(2'($urandom), ($urandom_range(0, 3) == 0), rand_instr(), rand_instr(),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                 3'($urandom), 1'($urandom));
        end

        // Freeze holds counters; clear overrides freeze
        do_clear();
        repeat (2) step(2'b01, 1'b0, I_JAL, I_NOP, 1'b0, 1'b0, 3'd5, 1'b0);
        repeat (5) step(2'b11, 1'b0, I_JAL, I_JAL, 1'b0, 1'b1, 3'd5, 1'b0);
        readout(3'd5, 1'b0); chk("freeze_branch", 64'(rd_data), 64'd2);
        readout(3'd0, 1'b0); chk("freeze_cycle", 64'(rd_data), 64'd2);
        step(2'b00, 1'b0, I_NOP, I_NOP, 1'b1, 1'b1, 3'd0, 1'b0);
        readout(3'd0, 1'b0); chk("clr_frz_cycle", 64'(rd_data), 64'd0);
        readout(3'd5, 1'b0); chk("clr_frz_branch", 64'(rd_data), 64'd0);

        // Saturation of the 16-bit cycle counter
        do_clear();
        repeat (65534) step(2'b00, 1'b0, I_NOP, I_NOP, 1'b0, 1'b0, 3'd0, 1'b0);
        repeat (2) step(2'b11, 1'b0, I_ADD, I_ADD, 1'b0, 1'b0, 3'd0, 1'b0);
        readout(3'd0, 1'b0); chk("sat_cycle", 64'(rd_data), 64'hFFFF);
        chk("sat_ovf", 64'(ovf), 64'h01);
        readout(3'd1, 1'b0); chk("sat_retire", 64'(rd_data), 64'd4);
        do_clear();
        readout(3'd0, 1'b0); chk("sat_clr_cycle", 64'(rd_data), 64'd0);
        chk("sat_clr_ovf", 64'(ovf), 64'd0);

        // Asynchronous reset mid-window
        do_clear();
        repeat (3) step(2'b11, 1'b0, I_ADD, I_ADD, 1'b0, 1'b0, 3'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rd", 64'(rd_data), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        chk("arst_snapv", 64'(snap_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_snapv", 64'(snap_valid), 64'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(2'b11, 1'b0, I_ADD, I_ADD, 1'b0, 1'b0, 3'd2, 1'b1);
        chk("arst_snap_cleared", 64'(rd_data), 64'd0);
        repeat (5) step(2'b11, 1'b0, I_ADD, I_ADD, 1'b0, 1'b0, 3'd2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
